// File: rtl/sao_lcu_feeder.sv
// Streams a 128x128 8-bit frame to the SAO filter one LCU at a time, with per-LCU parameters.
// Define SAO_FEED_WDOG_EN to add a watchdog on the busy/finish waits (WDOG_MAX, sticky wdog_err).
module sao_lcu_feeder #(
    parameter int LCU_GAP = 2
`ifdef SAO_FEED_WDOG_EN
    ,
    parameter int WDOG_MAX = 65535
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  cfg_lcu_size,
    output logic        frm_ren,
    output logic [13:0] frm_addr,
    input  logic [7:0]  frm_rdata,
    output logic        par_ren,
    output logic [5:0]  par_addr,
    input  logic [23:0] par_rdata,
    input  logic        busy,
    input  logic        finish,
    output logic        in_en,
    output logic [7:0]  din,
    output logic [1:0]  sao_type,
    output logic [4:0]  sao_band_pos,
    output logic        sao_eo_class,
    output logic [15:0] sao_offset,
    output logic [2:0]  lcu_x,
    output logic [2:0]  lcu_y,
    output logic [1:0]  lcu_size,
    output logic        done
`ifdef SAO_FEED_WDOG_EN
    ,
    output logic        wdog_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        PARAM,
        PRIME,
        STREAM,
        GAP,
        WAIT_FIN,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  lcu_idx;
    logic [11:0] pix_cnt;
    logic [3:0]  gap_cnt;

    logic [11:0] last_pix;
    logic [5:0]  last_lcu;
    logic [2:0]  cur_x, cur_y;
    logic [12:0] rd_pix;
    logic [13:0] rd_addr;
    logic        rd_ok;
    logic        stream_last;
    logic        gap_done;

    // Size-dependent limits and the LCU coordinates implied by the running index
    always_comb begin
        last_pix = 12'd4095;
        last_lcu = 6'd3;
        cur_x    = {2'b00, lcu_idx[0]};
        cur_y    = {2'b00, lcu_idx[1]};
        case (lcu_size)
            2'd0: begin
                last_pix = 12'd255;
                last_lcu = 6'd63;
                cur_x    = lcu_idx[2:0];
                cur_y    = lcu_idx[5:3];
            end
            2'd1: begin
                last_pix = 12'd1023;
                last_lcu = 6'd15;
                cur_x    = {1'b0, lcu_idx[1:0]};
                cur_y    = {1'b0, lcu_idx[3:2]};
            end
            default: ;
        endcase
    end

    // Reads run two pixels ahead of din to cover the one-cycle memory latency
    always_comb begin
        rd_pix = 13'd0;
        case (state)
            PRIME:   rd_pix = 13'd1;
            STREAM:  rd_pix = {1'b0, pix_cnt} + 13'd2;
            default: ;
        endcase
    end

    always_comb begin
        case (lcu_size)
            2'd0:    rd_addr = {cur_y, rd_pix[7:4], cur_x, rd_pix[3:0]};
            2'd1:    rd_addr = {cur_y[1:0], rd_pix[9:5], cur_x[1:0], rd_pix[4:0]};
            default: rd_addr = {cur_y[0], rd_pix[11:6], cur_x[0], rd_pix[5:0]};
        endcase
    end

    assign rd_ok       = rd_pix <= {1'b0, last_pix};
    assign frm_ren     = (state == PARAM) || (((state == PRIME) || (state == STREAM)) && rd_ok);
    assign frm_addr    = frm_ren ? rd_addr : 14'd0;
    assign par_ren     = (state == PARAM);
    assign par_addr    = lcu_idx;
    assign in_en       = (state == STREAM);
    assign done        = (state == DONE);
    assign stream_last = (pix_cnt == last_pix);
    assign gap_done    = !busy && (gap_cnt == 4'(LCU_GAP - 1));

`ifdef SAO_FEED_WDOG_EN
    localparam int WDW = $clog2(WDOG_MAX + 1);

    logic [WDW-1:0] wdog_cnt;
    logic           wdog_run;
    logic           wdog_hit;

    assign wdog_run = ((state == GAP) && busy) || (state == WAIT_FIN);
    assign wdog_hit = wdog_run && (wdog_cnt == WDW'(WDOG_MAX - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            wdog_cnt <= (wdog_run && !wdog_hit) ? wdog_cnt + 1'b1 : '0;
            if (wdog_hit)
                wdog_err <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = PARAM;
            PARAM:    state_nxt = PRIME;
            PRIME:    state_nxt = STREAM;
            STREAM:   if (stream_last) state_nxt = GAP;
            GAP:      if (gap_done) state_nxt = (lcu_idx == last_lcu) ? WAIT_FIN : PARAM;
            WAIT_FIN: if (finish) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
`ifdef SAO_FEED_WDOG_EN
        if (wdog_hit)
            state_nxt = DONE;
`endif
    end

    // Parameters and coordinates move only in PRIME so they hold for the whole LCU
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lcu_size     <= 2'd0;
            lcu_idx      <= 6'd0;
            pix_cnt      <= 12'd0;
            gap_cnt      <= 4'd0;
            din          <= 8'd0;
            sao_type     <= 2'd0;
            sao_band_pos <= 5'd0;
            sao_eo_class <= 1'b0;
            sao_offset   <= 16'd0;
            lcu_x        <= 3'd0;
            lcu_y        <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lcu_size <= cfg_lcu_size;
                        lcu_idx  <= 6'd0;
                    end
                end
                PRIME: begin
                    {sao_type, sao_band_pos, sao_eo_class, sao_offset} <= par_rdata;
                    lcu_x   <= cur_x;
                    lcu_y   <= cur_y;
                    din     <= frm_rdata;
                    pix_cnt <= 12'd0;
                end
                STREAM: begin
                    din     <= frm_rdata;
                    pix_cnt <= pix_cnt + 12'd1;
                    gap_cnt <= 4'd0;
                end
                GAP: begin
                    if (busy) begin
                        gap_cnt <= 4'd0;
                    end else if (gap_done) begin
                        gap_cnt <= 4'd0;
                        if (lcu_idx != last_lcu)
                            lcu_idx <= lcu_idx + 6'd1;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sao_lcu_feeder.sv
// Bench for sao_lcu_feeder: a table of whole-frame runs checked against a frame/parameter memory
// model, plus busy-hold, mid-frame reset, restart and (with SAO_FEED_WDOG_EN) watchdog sequences.
module tb_sao_lcu_feeder;

    localparam int LCU_GAP = 2;
`ifdef SAO_FEED_WDOG_EN
    localparam int WDOG_MAX = 100;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  cfg_lcu_size;
    logic        frm_ren;
    logic [13:0] frm_addr;
    logic [7:0]  frm_rdata = 8'd0;
    logic        par_ren;
    logic [5:0]  par_addr;
    logic [23:0] par_rdata = 24'd0;
    logic        busy;
    logic        finish;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  sao_type;
    logic [4:0]  sao_band_pos;
    logic        sao_eo_class;
    logic [15:0] sao_offset;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size;
    logic        done;
`ifdef SAO_FEED_WDOG_EN
    logic        wdog_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]  fmem [16384];
    logic [23:0] pmem [64];

    typedef struct {
        logic [1:0] cfg;
        int         busy_max;
        bit         addr_fill;
        bit         glitch;
        int         exp_n;
        int         exp_r;
        int         exp_lcus;
        logic [1:0] exp_size;
        int         probe_idx;
        int         probe_din;
    } frame_vec_t;

    frame_vec_t vecs [3];

    sao_lcu_feeder #(
        .LCU_GAP(LCU_GAP)
`ifdef SAO_FEED_WDOG_EN
        ,
        .WDOG_MAX(WDOG_MAX)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .cfg_lcu_size(cfg_lcu_size),
        .frm_ren(frm_ren),
        .frm_addr(frm_addr),
        .frm_rdata(frm_rdata),
        .par_ren(par_ren),
        .par_addr(par_addr),
        .par_rdata(par_rdata),
        .busy(busy),
        .finish(finish),
        .in_en(in_en),
        .din(din),
        .sao_type(sao_type),
        .sao_band_pos(sao_band_pos),
        .sao_eo_class(sao_eo_class),
        .sao_offset(sao_offset),
        .lcu_x(lcu_x),
        .lcu_y(lcu_y),
        .lcu_size(lcu_size),
        .done(done)
`ifdef SAO_FEED_WDOG_EN
        ,
        .wdog_err(wdog_err)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous external memories: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (frm_ren) frm_rdata <= fmem[frm_addr];
        if (par_ren) par_rdata <= pmem[par_addr];
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL sim_timeout: still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic flag(inout int errs, inout string note, input string msg);
        if (errs == 0) note = msg;
        errs++;
    endtask

    function automatic logic [63:0] all_outputs();
        return {frm_ren, frm_addr, par_ren, par_addr, in_en, din, sao_type, sao_band_pos,
                sao_eo_class, sao_offset, lcu_x, lcu_y, lcu_size, done};
    endfunction

    // Pixel k of LCU idx, as a linear address into the 128-wide frame
    function automatic int exp_addr(input int n, input int r, input int idx, input int k);
        int x, y, px, py;
        x  = idx % r;
        y  = idx / r;
        px = k % n;
        py = k / n;
        return (y * n + py) * 128 + x * n + px;
    endfunction

    task automatic fill_mem(input bit addr_fill);
        for (int a = 0; a < 16384; a++)
            fmem[a] = addr_fill ? 8'(a) : 8'($urandom);
        for (int i = 0; i < 64; i++)
            pmem[i] = 24'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        busy = 1'b0;
        finish = 1'b0;
        cfg_lcu_size = 2'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Waits for one LCU, checks its lead-in gap and reads, then every pixel of its stream.
    // prev_busy < 0 marks the first LCU after start; busy_after raises busy on the last pixel.
    task automatic stream_lcu(input int n, input int r, input int idx, input int prev_busy,
                              input int busy_after, input bit glitch, input int stop_at,
                              output int low, output logic [7:0] first_din);
        int    errs = 0;
        int    frm_reads = 0;
        int    par_reads = 0;
        int    exp_low;
        bit    seen = 1'b0;
        string note = "";
        low = 0;
        first_din = 8'd0;
        exp_low = (prev_busy < 0) ? 2 : LCU_GAP + 2 + ((prev_busy > 1) ? prev_busy - 1 : 0);
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (prev_busy > 0 && i == prev_busy) busy = 1'b0;
            if (in_en) begin
                seen = 1'b1;
                break;
            end
            low++;
            if (par_ren) begin
                if (par_addr != 6'(idx))
                    flag(errs, note, $sformatf("par_addr %0d", par_addr));
                par_reads++;
            end
            if (frm_ren) begin
                if (frm_addr != 14'(exp_addr(n, r, idx, frm_reads)))
                    flag(errs, note, $sformatf("lead-in frm_addr %0d", frm_addr));
                frm_reads++;
            end
            if (done) flag(errs, note, "done during gap");
        end
        if (!seen) begin
            check_output($sformatf("lcu%0d in_en arrival", idx), 0, 1);
            return;
        end
        check_output($sformatf("lcu%0d gap cycles", idx), low, exp_low);
        if (par_reads != 1 || frm_reads != 2)
            flag(errs, note, $sformatf("lead-in reads par=%0d frm=%0d", par_reads, frm_reads));
        for (int k = 0; k < n * n; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) first_din = din;
            if (glitch) begin
                if (k == 50) begin
                    start = 1'b1;
                    cfg_lcu_size = 2'd1;
                end else begin
                    start = 1'b0;
                end
            end
            if (!in_en) flag(errs, note, $sformatf("in_en low at pixel %0d", k));
            if (din != fmem[exp_addr(n, r, idx, k)])
                flag(errs, note, $sformatf("din %0d at pixel %0d", din, k));
            if ({sao_type, sao_band_pos, sao_eo_class, sao_offset} != pmem[idx])
                flag(errs, note, $sformatf("parameters at pixel %0d", k));
            if (lcu_x != 3'(idx % r) || lcu_y != 3'(idx / r))
                flag(errs, note, $sformatf("coords (%0d,%0d) at pixel %0d", lcu_x, lcu_y, k));
            if (frm_ren != (k + 2 < n * n))
                flag(errs, note, $sformatf("frm_ren %0d at pixel %0d", frm_ren, k));
            else if (frm_ren && frm_addr != 14'(exp_addr(n, r, idx, k + 2)))
                flag(errs, note, $sformatf("frm_addr %0d at pixel %0d", frm_addr, k));
            if (k == n * n - 1 && busy_after > 0) busy = 1'b1;
            if (k == stop_at) break;
        end
        check_output($sformatf("lcu%0d stream errors", idx), errs, 0);
        if (errs != 0) $display("[TB] lcu%0d first problem: %s", idx, note);
    endtask

    // After the last LCU: no further pixels or done until finish, then a one-cycle done
    task automatic finish_frame();
        int errs = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (in_en || done) errs++;
        end
        check_output("post-frame quiet", errs, 0);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        check_output("done after finish", done, 1);
        @(negedge clk);
        check_output("done one cycle", done, 0);
    endtask

    task automatic apply_stimulus(input frame_vec_t v);
        int         low;
        int         prev = -1;
        int         b;
        logic [7:0] fd;
        fill_mem(v.addr_fill);
        @(negedge clk);
        cfg_lcu_size = v.cfg;
        start = 1'b1;
        for (int idx = 0; idx < v.exp_lcus; idx++) begin
            b = (idx == v.exp_lcus - 1) ? 0 : int'($urandom_range(0, v.busy_max));
            stream_lcu(v.exp_n, v.exp_r, idx, prev, b, v.glitch && idx == 0, -1, low, fd);
            prev = b;
            if (idx == v.probe_idx) check_output("probe first din", fd, 64'(v.probe_din));
        end
        check_output("latched lcu_size", lcu_size, v.exp_size);
        finish_frame();
        cfg_lcu_size = 2'd0;
    endtask

    initial begin
        int         low;
        logic [7:0] fd;

        reset = 1'b0;
        start = 1'b0;
        cfg_lcu_size = 2'd0;
        busy = 1'b0;
        finish = 1'b0;

        vecs[0] = '{cfg: 2'd0, busy_max: 0, addr_fill: 1'b1, glitch: 1'b0, exp_n: 16, exp_r: 8,
                    exp_lcus: 64, exp_size: 2'd0, probe_idx: 43, probe_din: 48};
        vecs[1] = '{cfg: 2'd1, busy_max: 6, addr_fill: 1'b0, glitch: 1'b0, exp_n: 32, exp_r: 4,
                    exp_lcus: 16, exp_size: 2'd1, probe_idx: -1, probe_din: 0};
        vecs[2] = '{cfg: 2'd2, busy_max: 4, addr_fill: 1'b0, glitch: 1'b1, exp_n: 64, exp_r: 2,
                    exp_lcus: 4, exp_size: 2'd2, probe_idx: -1, probe_din: 0};

        repeat (2) @(negedge clk);
        check_output("outputs in reset", all_outputs(), 0);
`ifdef SAO_FEED_WDOG_EN
        check_output("wdog_err in reset", wdog_err, 0);
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_output("outputs idle", all_outputs(), 0);

        for (int i = 0; i < 3; i++) begin
            $display("[TB] frame vector %0d cfg=%0d", i, vecs[i].cfg);
            apply_stimulus(vecs[i]);
        end

        // Busy held 37 cycles starting on the last pixel of LCU 0
        fill_mem(1'b0);
        @(negedge clk);
        cfg_lcu_size = 2'd0;
        start = 1'b1;
        stream_lcu(16, 8, 0, -1, 37, 1'b0, -1, low, fd);
        stream_lcu(16, 8, 1, 37, 0, 1'b0, 20, low, fd);
        check_output("busy37 last-pixel to in_en", low + 1, 37 + LCU_GAP + 2);
        do_reset();

        // Reset at pixel 100 of LCU 2, then a fresh 64x64 start from LCU (0,0)
        fill_mem(1'b0);
        @(negedge clk);
        start = 1'b1;
        stream_lcu(16, 8, 0, -1, 0, 1'b0, -1, low, fd);
        stream_lcu(16, 8, 1, 0, 0, 1'b0, -1, low, fd);
        stream_lcu(16, 8, 2, 0, 0, 1'b0, 100, low, fd);
        reset = 1'b0;
        #1;
        check_output("async reset clears outputs", all_outputs(), 0);
        @(negedge clk);
        check_output("outputs held in reset", all_outputs(), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_output("no restart without start", in_en | frm_ren | par_ren, 0);
        cfg_lcu_size = 2'd3;
        start = 1'b1;
        stream_lcu(64, 2, 0, -1, 0, 1'b0, -1, low, fd);
        check_output("size code 3 latched", lcu_size, 3);
        do_reset();

`ifdef SAO_FEED_WDOG_EN
        // No finish: watchdog must end the frame WDOG_MAX cycles into WAIT_FIN
        begin
            int wait_cycles = 0;
            fill_mem(1'b0);
            @(negedge clk);
            cfg_lcu_size = 2'd2;
            start = 1'b1;
            for (int idx = 0; idx < 4; idx++)
                stream_lcu(64, 2, idx, (idx == 0) ? -1 : 0, 0, 1'b0, -1, low, fd);
            for (int i = 1; i <= 400; i++) begin
                @(negedge clk);
                wait_cycles = i;
                if (done) break;
            end
            check_output("wdog done delay", wait_cycles, LCU_GAP + 1 + WDOG_MAX);
            check_output("wdog_err set", wdog_err, 1);
            @(negedge clk);
            check_output("wdog done one cycle", done, 0);
            check_output("wdog_err sticky", wdog_err, 1);
            do_reset();
            @(negedge clk);
            check_output("wdog_err cleared by reset", wdog_err, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
